// File: rtl/mem_request_ctrl_pkg.sv
// Shared types and constants for the memory request controller.
package mem_request_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DPEND  = 2'd1,
    HALTED = 2'd2
  } mrc_state_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Watchdog width: must be able to hold TIMEOUT-1 and still saturate above it.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_request_ctrl_if.sv
// Pipeline/bus signal bundle for the memory request controller.
interface mem_request_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              ihit;
  logic              dhit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              cpu_halt;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              halt;
  logic              busy;
  logic              timeout_err;
  logic              proto_err;
  logic [CNT_W-1:0]  req_count;

  modport ru (
    input  ihit, dhit, dREN, dWEN, daddr, dstore, cpu_halt,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
           halt, busy, timeout_err, proto_err, req_count
  );

  modport tb (
    output ihit, dhit, dREN, dWEN, daddr, dstore, cpu_halt,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
           halt, busy, timeout_err, proto_err, req_count
  );
endinterface

// File: rtl/mem_request_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (inc_i && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  // Count register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/mem_request_ctrl.sv
// Data request unit: latches a MEM-stage access on ihit, holds it until dhit,
// defers halt until the bus is drained, and tracks watchdog/protocol errors.
module mem_request_ctrl
  import mem_request_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int WORD_W        = 32,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT,
  parameter int CNT_W         = 16,
  parameter int IMEM_SUPPRESS = 0
) (
  input logic            CLK,
  input logic            nRST,
  mem_request_ctrl_if.ru rif
);
  localparam int WD_W = wd_width(TIMEOUT);

  mrc_state_t        state_q, state_d;
  logic              imem_q, imem_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              halt_q, halt_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic              perr_q, perr_d;
  logic              hpend_q, hpend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;

  logic              capture;
  logic              done;
  logic              wd_hit;
  logic [WD_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]  cnt;

  assign capture = (state_q == IDLE) && !rif.cpu_halt && rif.ihit && (rif.dREN || rif.dWEN);
  assign done    = (state_q == DPEND) && rif.dhit;

  // Watchdog restarts from zero every time the request is (re)entered.
  sat_counter #(.W(WD_W)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear_i (state_q != DPEND),
    .inc_i   ((state_q == DPEND) && !rif.dhit),
    .count_o (wd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_req_count (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear_i (1'b0),
    .inc_i   (done),
    .count_o (cnt)
  );

  generate
    if (TIMEOUT == 0) begin : g_no_wd
      assign wd_hit = 1'b0;
    end else begin : g_wd
      assign wd_hit = (state_q == DPEND) && (wd_cnt == WD_W'(TIMEOUT - 1));
    end
  endgenerate

  // Next state and next registered outputs; halt beats capture, requests are never dropped.
  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    perr_d  = perr_q;
    hpend_d = hpend_q;
    terr_d  = terr_q | wd_hit;
    case (state_q)
      IDLE: begin
        if (rif.cpu_halt) begin
          state_d = HALTED;
        end else if (capture) begin
          state_d = DPEND;
          addr_d  = rif.daddr;
          store_d = rif.dstore;
          ren_d   = rif.dREN & ~rif.dWEN;
          wen_d   = rif.dWEN;
          perr_d  = perr_q | (rif.dREN & rif.dWEN);
        end
      end
      DPEND: begin
        hpend_d = hpend_q | rif.cpu_halt;
        if (rif.dhit) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          hpend_d = 1'b0;
          state_d = (hpend_q || rif.cpu_halt) ? HALTED : IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    imem_d = (state_d == IDLE) || ((state_d == DPEND) && (IMEM_SUPPRESS == 0));
    halt_d = (state_d == HALTED);
    busy_d = (state_d == DPEND);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      imem_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
      hpend_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      imem_q  <= imem_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
      hpend_q <= hpend_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

  assign rif.imemREN     = imem_q;
  assign rif.dmemREN     = ren_q;
  assign rif.dmemWEN     = wen_q;
  assign rif.dmemaddr    = addr_q;
  assign rif.dmemstore   = store_q;
  assign rif.halt        = halt_q;
  assign rif.busy        = busy_q;
  assign rif.timeout_err = terr_q;
  assign rif.proto_err   = perr_q;
  assign rif.req_count   = cnt;
endmodule

// File: tb/tb_mem_request_ctrl.sv
// Scoreboard bench for mem_request_ctrl: two instances (fetch suppression on/off)
// share one stimulus stream and are checked against a transaction-level model.
module tb_mem_request_ctrl;
  localparam int AW   = 32;
  localparam int WW   = 32;
  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK;
  logic nRST;
  logic ihit, dhit, dREN, dWEN, cpu_halt;
  logic [AW-1:0] daddr;
  logic [WW-1:0] dstore;

  mem_request_ctrl_if #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW)) if_s ();
  mem_request_ctrl_if #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW)) if_n ();

  assign if_s.ihit = ihit;   assign if_n.ihit = ihit;
  assign if_s.dhit = dhit;   assign if_n.dhit = dhit;
  assign if_s.dREN = dREN;   assign if_n.dREN = dREN;
  assign if_s.dWEN = dWEN;   assign if_n.dWEN = dWEN;
  assign if_s.daddr = daddr; assign if_n.daddr = daddr;
  assign if_s.dstore = dstore; assign if_n.dstore = dstore;
  assign if_s.cpu_halt = cpu_halt; assign if_n.cpu_halt = cpu_halt;

  mem_request_ctrl #(.ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO), .CNT_W(CW), .IMEM_SUPPRESS(1))
    u_sup (.CLK(CLK), .nRST(nRST), .rif(if_s));
  mem_request_ctrl #(.ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO), .CNT_W(CW), .IMEM_SUPPRESS(0))
    u_nos (.CLK(CLK), .nRST(nRST), .rif(if_n));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic          imem_s;
    logic          imem_n;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [WW-1:0] store;
    logic          halt;
    logic          busy;
    logic          terr;
    logic          perr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding request record plus sticky flags.
  bit            m_pend, m_halted, m_rd, m_wr, m_hp, m_terr, m_perr;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_store;
  int            m_wait, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_halted = 0; m_rd = 0; m_wr = 0; m_hp = 0; m_terr = 0; m_perr = 0;
    m_addr = '0; m_store = '0; m_wait = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, predict the outputs after the next edge, wait a cycle.
  task automatic step(input bit ih, input bit dh, input bit rn, input bit wn,
                      input logic [AW-1:0] a, input logic [WW-1:0] s, input bit ch);
    exp_t e;
    ihit = ih; dhit = dh; dREN = rn; dWEN = wn; daddr = a; dstore = s; cpu_halt = ch;
    if (m_halted) begin
      // absorbing
    end else if (!m_pend) begin
      if (ch) m_halted = 1;
      else if (ih && (rn || wn)) begin
        m_pend = 1; m_wr = wn; m_rd = rn && !wn; m_addr = a; m_store = s; m_wait = 0;
        if (rn && wn) m_perr = 1;
      end
    end else begin
      if (m_wait >= TO - 1) m_terr = 1;
      if (dh) begin
        if (m_cnt < CMAX) m_cnt++;
        m_pend = 0; m_rd = 0; m_wr = 0;
        if (m_hp || ch) m_halted = 1;
        m_hp = 0;
      end else begin
        m_wait++;
        if (ch) m_hp = 1;
      end
    end
    e.imem_s = !m_halted && !m_pend;
    e.imem_n = !m_halted;
    e.ren    = m_pend && m_rd;
    e.wen    = m_pend && m_wr;
    e.addr   = m_addr;
    e.store  = m_store;
    e.halt   = m_halted;
    e.busy   = m_pend;
    e.terr   = m_terr;
    e.perr   = m_perr;
    e.cnt    = CW'(m_cnt);
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input bit ch);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, ch);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2 nRST = 1'b0;
    #1;
    check("rst_imem_s", 32'(if_s.imemREN), 0);
    check("rst_imem_n", 32'(if_n.imemREN), 0);
    check("rst_ren", 32'(if_s.dmemREN), 0);
    check("rst_wen", 32'(if_s.dmemWEN), 0);
    check("rst_addr", if_s.dmemaddr, 0);
    check("rst_store", if_s.dmemstore, 0);
    check("rst_halt", 32'(if_s.halt), 0);
    check("rst_busy", 32'(if_s.busy), 0);
    check("rst_terr", 32'(if_s.timeout_err), 0);
    check("rst_perr", 32'(if_s.proto_err), 0);
    check("rst_cnt", 32'(if_s.req_count), 0);
    check("rst_cnt_n", 32'(if_n.req_count), 0);
    ihit = 0; dhit = 0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0; cpu_halt = 0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Monitor: compare every registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imemREN_sup", 32'(if_s.imemREN), 32'(e.imem_s));
        check("imemREN_nosup", 32'(if_n.imemREN), 32'(e.imem_n));
        check("dmemREN", 32'(if_s.dmemREN), 32'(e.ren));
        check("dmemWEN", 32'(if_s.dmemWEN), 32'(e.wen));
        check("dmemaddr", if_s.dmemaddr, e.addr);
        check("dmemstore", if_s.dmemstore, e.store);
        check("halt", 32'(if_s.halt), 32'(e.halt));
        check("busy", 32'(if_s.busy), 32'(e.busy));
        check("timeout_err", 32'(if_s.timeout_err), 32'(e.terr));
        check("proto_err", 32'(if_s.proto_err), 32'(e.perr));
        check("req_count", 32'(if_s.req_count), 32'(e.cnt));
        check("dmemREN_nosup", 32'(if_n.dmemREN), 32'(e.ren));
        check("halt_nosup", 32'(if_n.halt), 32'(e.halt));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int dh_pct;
    nRST = 1'b0;
    ihit = 0; dhit = 0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0; cpu_halt = 0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Load, completed after 3 waiting cycles; a same-cycle ihit is not captured.
    idle(2, 0);
    step(1, 0, 1, 0, 32'h100, 32'h0, 0);
    idle(3, 0);
    step(1, 1, 1, 0, 32'h200, 32'h5, 0);
    step(1, 0, 1, 0, 32'h200, 32'h5, 0);
    step(0, 1, 0, 0, '0, '0, 0);
    idle(2, 0);
    do_reset();

    // Store with both enables: write wins, proto_err sticks.
    step(1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0);
    idle(1, 0);
    step(0, 1, 0, 0, '0, '0, 0);
    idle(3, 0);
    step(0, 1, 0, 0, '0, '0, 0);
    do_reset();

    // Halt raised while a load is pending; halt waits for dhit.
    step(1, 0, 1, 0, 32'h300, 32'h0, 0);
    idle(4, 1);
    step(0, 1, 0, 0, '0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 32'h999, 32'h1, 1);
    idle(2, 0);
    do_reset();

    // Watchdog: no dhit for a while, then a normal completion.
    step(1, 0, 1, 0, 32'h400, 32'h0, 0);
    idle(6, 0);
    step(0, 1, 0, 0, '0, '0, 0);
    idle(2, 0);
    do_reset();

    // Halt in IDLE beats a simultaneous capture.
    step(1, 0, 1, 0, 32'h500, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h504, 32'h0, 0);
    do_reset();

    // Completion, then async reset while the next request is pending.
    step(1, 0, 0, 1, 32'h600, 32'h12345678, 0);
    step(0, 1, 0, 0, '0, '0, 0);
    step(1, 0, 1, 0, 32'h604, 32'h0, 0);
    idle(2, 0);
    do_reset();
    idle(2, 0);

    // Randomized traffic; alternating fast and slow memory.
    for (int seg = 0; seg < 6; seg++) begin
      dh_pct = (seg % 2 == 0) ? 50 : 20;
      for (int c = 0; c < 70; c++) begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) < dh_pct),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0),
             $urandom, $urandom,
             1'((seg >= 4) && ($urandom_range(0, 99) < 3)));
      end
      do_reset();
      idle(1, 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
